// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding and framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// MSB-first byte-to-word shift register; word_valid flags the byte that
// completes a 32-bit word (combinational, same cycle as the shift).
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] count;

    assign word_valid = shift && (count == CNT_W'(WORD_BYTES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (shift) begin
            word  <= {word[23:0], in_data};
            count <= word_valid ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: parses framed byte stream, writes
// packed words at consecutive addresses, releases cpu_hold on a good checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [31:0] CAPACITY = (32'd1 << ADDR_W) - 32'(START_ADDR);

    state_t      state, next_state;
    logic        accept;
    logic        sync_state;
    logic        sync_hit;
    logic [7:0]  len_hi;
    logic [15:0] len_full;
    logic        len_overflow;
    logic [15:0] word_cnt;
    logic [7:0]  csum_acc;
    logic        word_valid;
    logic [31:0] packed_word;

    assign in_ready     = (state != S_WRITE);
    assign imem_we      = (state == S_WRITE);
    assign imem_wdata   = packed_word;
    assign accept       = in_valid && in_ready;
    assign sync_state   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign sync_hit     = accept && sync_state && (in_data == SYNC_BYTE);
    assign len_full     = {len_hi, in_data};
    assign len_overflow = 32'(len_full) > CAPACITY;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (sync_hit),
        .shift      (accept && (state == S_DATA)),
        .in_data    (in_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (sync_hit) next_state = S_LEN_HI;
            S_LEN_HI:              if (accept) next_state = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_overflow)        next_state = S_ERR;
                    else if (len_full == 0)  next_state = S_CSUM;
                    else                     next_state = S_DATA;
                end
            end
            S_DATA:  if (word_valid) next_state = S_WRITE;
            // word_cnt still holds the pre-decrement count here
            S_WRITE: next_state = (word_cnt == 16'd1) ? S_CSUM : S_DATA;
            S_CSUM: begin
                if (accept) next_state = (in_data == csum_acc) ? S_DONE : S_ERR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi    <= '0;
            word_cnt  <= '0;
            csum_acc  <= '0;
            imem_addr <= ADDR_W'(START_ADDR);
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (sync_hit) begin
                csum_acc  <= '0;
                imem_addr <= ADDR_W'(START_ADDR);
                cpu_hold  <= 1'b1;
                done      <= 1'b0;
                error     <= 1'b0;
            end else if (accept && (state == S_LEN_HI || state == S_LEN_LO || state == S_DATA)) begin
                csum_acc <= csum_acc ^ in_data;
            end

            if (accept && state == S_LEN_HI) len_hi <= in_data;

            if (accept && state == S_LEN_LO) begin
                word_cnt <= len_full;
                if (len_overflow) error <= 1'b1;
            end

            if (state == S_WRITE) begin
                imem_addr <= imem_addr + ADDR_W'(1);
                word_cnt  <= word_cnt - 16'd1;
            end

            if (accept && state == S_CSUM) begin
                if (in_data == csum_acc) begin
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end else begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule
